// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Frame-synchronous buffered updates, guard-time blanking, leading-zero blanking and per-digit blink.
module seg_scan_ctrl #(
    parameter int DIV          = 50000,
    parameter int GUARD        = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    input  logic [7:0] seg3,
    input  logic       upd_valid,
    output logic       upd_ready,
    input  logic       blank_lz,
    input  logic [3:0] blink_en,
    output logic [3:0] an,
    output logic [7:0] seg,
    output logic       frame_tick
);

    localparam int PW = $clog2(DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0] GUARD_END = PW'(GUARD);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]   pre_reg;
    logic [1:0]      idx_reg;
    logic [3:0][7:0] active_reg;
    logic [3:0][7:0] pending_reg;
    logic            pending_full_reg;
    logic [FW-1:0]   frame_cnt_reg;
    logic            blink_phase_reg;
    logic [3:0]      an_reg;
    logic [7:0]      seg_reg;
    logic            frame_tick_reg;

    logic [3:0]      an_next;
    logic [7:0]      seg_next;
    logic [3:0]      blank;
    logic [3:0][7:0] disp;
    logic [3:0][7:0] seg_in;
    logic            wrap;
    logic            xfer;

    assign seg_in    = {seg3, seg2, seg1, seg0};
    assign wrap      = (idx_reg == 2'd3) && (pre_reg == PRE_LAST);
    assign upd_ready = !pending_full_reg;
    assign xfer      = upd_valid && !pending_full_reg;

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign frame_tick = frame_tick_reg;

    // Leading-zero chain runs from the most significant digit down; digit0 always shows.
    assign blank[0] = 1'b0;
    assign blank[3] = blank_lz && (active_reg[3] == 8'hC0);
    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_lz
            assign blank[gi] = blank[gi+1] && (active_reg[gi] == 8'hC0);
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_disp
            assign disp[gi] = (blank[gi] || (blink_en[gi] && blink_phase_reg)) ? 8'hFF
                                                                               : active_reg[gi];
        end
    endgenerate

    always_comb begin
        an_next  = 4'hF;
        seg_next = 8'hFF;
        if (pre_reg >= GUARD_END) begin
            an_next  = ~(4'b0001 << idx_reg);
            seg_next = disp[idx_reg];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg <= '0;
            idx_reg <= 2'd0;
        end else if (pre_reg == PRE_LAST) begin
            pre_reg <= '0;
            idx_reg <= idx_reg + 2'd1;
        end else begin
            pre_reg <= pre_reg + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            frame_tick_reg  <= 1'b0;
        end else begin
            frame_tick_reg <= wrap;
            if (wrap) begin
                if (frame_cnt_reg == FRAME_LAST) begin
                    frame_cnt_reg   <= '0;
                    blink_phase_reg <= !blink_phase_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + FW'(1);
                end
            end
        end
    end

    // Active only changes on the frame boundary; an update accepted in that very cycle skips pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg       <= {4{8'hFF}};
            pending_reg      <= {4{8'hFF}};
            pending_full_reg <= 1'b0;
        end else if (wrap && pending_full_reg) begin
            active_reg       <= pending_reg;
            pending_full_reg <= 1'b0;
        end else if (wrap && xfer) begin
            active_reg <= seg_in;
        end else if (xfer) begin
            pending_reg      <= seg_in;
            pending_full_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_reg  <= 4'hF;
            seg_reg <= 8'hFF;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl: a cycle-count based reference model predicts
// every output each cycle, covering updates, blanking, blink and mid-frame reset.
module tb_seg_scan_ctrl;

    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] seg0 = 8'hFF, seg1 = 8'hFF, seg2 = 8'hFF, seg3 = 8'hFF;
    logic       upd_valid = 1'b0;
    logic       upd_ready;
    logic       blank_lz = 1'b0;
    logic [3:0] blink_en = 4'h0;
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame_tick;

    seg_scan_ctrl #(.DIV(DIV), .GUARD(GUARD), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg0       (seg0),
        .seg1       (seg1),
        .seg2       (seg2),
        .seg3       (seg3),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state: what is shown, what waits, and cycles elapsed since reset release.
    logic [7:0] act  [4];
    logic [7:0] pend [4];
    bit         pend_full;
    int         cyc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pick_pattern();
        case ($urandom_range(0, 4))
            0, 1:    return 8'hC0;
            2:       return 8'h40;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            act[d]  = 8'hFF;
            pend[d] = 8'hFF;
        end
        pend_full = 1'b0;
        cyc       = 0;
    endtask

    // Called at a falling edge: drive inputs, predict, step one clock, compare.
    task automatic do_cycle(input bit force_valid);
        int         p, k;
        bit         w, phase, lead, take;
        bit         bl [4];
        logic [7:0] in_d [4];
        logic [3:0] exp_an;
        logic [7:0] exp_seg;

        upd_valid = force_valid ? 1'b1 : ($urandom_range(0, 15) == 0);
        seg0 = pick_pattern();
        seg1 = pick_pattern();
        seg2 = pick_pattern();
        seg3 = pick_pattern();
        if ($urandom_range(0, 47) == 0) blank_lz = 1'($urandom);
        if ($urandom_range(0, 47) == 0) blink_en = 4'($urandom);
        #1;
        check_val("upd_ready", {31'd0, upd_ready}, {31'd0, !pend_full});

        p     = cyc % DIV;
        k     = (cyc / DIV) % 4;
        w     = (cyc % FRAME) == FRAME - 1;
        phase = ((cyc / FRAME) / BF) % 2;

        lead  = blank_lz;
        bl[0] = 1'b0;
        for (int d = 3; d >= 1; d--) begin
            lead  = lead && (act[d] == 8'hC0);
            bl[d] = lead;
        end

        if (p < GUARD) begin
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
        end else begin
            exp_an  = 4'hF;
            exp_an[k] = 1'b0;
            exp_seg = (bl[k] || (blink_en[k] && phase)) ? 8'hFF : act[k];
        end

        in_d[0] = seg0; in_d[1] = seg1; in_d[2] = seg2; in_d[3] = seg3;
        take = upd_valid && !pend_full;
        if (take)
            $display("[TB] update accepted cyc=%0d d3..d0=%h %h %h %h%s", cyc,
                     seg3, seg2, seg1, seg0, w ? " (frame boundary)" : "");
        if (w && pend_full) begin
            act       = pend;
            pend_full = 1'b0;
        end else if (w && take) begin
            act = in_d;
        end else if (take) begin
            pend      = in_d;
            pend_full = 1'b1;
        end

        @(posedge clk);
        #1;
        check_val("an", {28'd0, an}, {28'd0, exp_an});
        check_val("seg", {24'd0, seg}, {24'd0, exp_seg});
        check_val("frame_tick", {31'd0, frame_tick}, {31'd0, w});
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        bit found;
        model_reset();
        @(negedge clk);
        #1;
        check_val("rst_an", {28'd0, an}, 32'hF);
        check_val("rst_seg", {24'd0, seg}, 32'hFF);
        check_val("rst_ready", {31'd0, upd_ready}, 32'd1);
        check_val("rst_tick", {31'd0, frame_tick}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 1200; i++) do_cycle(1'b0);
        // Back-to-back: valid held high, one update per frame.
        for (int i = 0; i < 200; i++) do_cycle(1'b1);
        for (int i = 0; i < 300; i++) do_cycle(1'b0);

        // Reach idx 2 mid-slot with an update pending, then reset.
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (pend_full && ((cyc / DIV) % 4) == 2 && (cyc % DIV) > GUARD)
                found = 1'b1;
            else
                do_cycle(i % 3 == 0);
        end
        check_val("rst_setup_found", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_an", {28'd0, an}, 32'hF);
        check_val("midrst_seg", {24'd0, seg}, 32'hFF);
        check_val("midrst_ready", {31'd0, upd_ready}, 32'd1);
        check_val("midrst_tick", {31'd0, frame_tick}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 600; i++) do_cycle(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
